// File: rtl/histo_readout.sv
// Histogram readout: snapshots 8 channel bins plus 64 interval bins on a host
// request and streams them as a header/data/checksum byte frame over valid/ready.
module histo_readout #(
  parameter int          NHISTO   = 8,
  parameter int          NIPI     = 64,
  parameter int          CLR_WAIT = 70,
  parameter logic [7:0]  HDR      = 8'hA5
) (
  input  logic                   clkin,
  input  logic                   resetn,
  input  logic [NHISTO*32-1:0]   histo,
  input  logic [NIPI*32-1:0]     ipihist,
  input  logic                   req,
  input  logic                   clear_after,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   resethist,
  output logic                   done
);

  localparam int              NWORDS    = NHISTO + NIPI;
  localparam int              CW        = $clog2(CLR_WAIT + 1);
  localparam logic [6:0]      LAST_WORD = 7'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECKSUM,
    S_CLEAR
  } state_t;

  state_t          r_state;
  logic [31:0]     r_snap [0:NWORDS-1];
  logic [6:0]      r_word;
  logic [1:0]      r_byte;
  logic [7:0]      r_chk;
  logic [CW-1:0]   r_cnt;
  logic            r_clr;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_busy;
  logic            r_resethist;
  logic            r_done;

  logic            w_accept;
  logic            w_xfer;
  logic            w_last;
  logic [6:0]      w_next_word;
  logic [1:0]      w_next_byte;
  logic [7:0]      w_next_data;

  assign w_accept    = (r_state == S_IDLE) && req;
  assign w_xfer      = r_tx_valid && tx_ready;
  assign w_last      = (r_word == LAST_WORD) && (r_byte == 2'd3);
  // Index of the byte that follows the one currently presented; clamped on the
  // final byte so the snapshot read never leaves the array.
  assign w_next_word = ((r_byte == 2'd3) && (r_word != LAST_WORD)) ? r_word + 7'd1 : r_word;
  assign w_next_byte = r_byte + 2'd1;
  assign w_next_data = r_snap[w_next_word][{w_next_byte, 3'b000} +: 8];

  // NOTE: snapshot storage carries no reset; it is always rewritten on accept
  // before any byte of it is presented, so resetting it would only add fan-out.
  always_ff @(posedge clkin) begin
    if (w_accept) begin
      for (int k = 0; k < NHISTO; k++) r_snap[k] <= histo[32*k +: 32];
      for (int k = 0; k < NIPI; k++)   r_snap[NHISTO + k] <= ipihist[32*k +: 32];
    end
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_resethist <= 1'b0;
      r_done      <= 1'b0;
      r_word      <= '0;
      r_byte      <= '0;
      r_chk       <= '0;
      r_cnt       <= '0;
      r_clr       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_resethist <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state    <= S_HEADER;
            r_tx_valid <= 1'b1;
            r_tx_data  <= HDR;
            r_busy     <= 1'b1;
            r_clr      <= clear_after;
          end
        end
        S_HEADER: begin
          if (w_xfer) begin
            r_state   <= S_DATA;
            r_word    <= '0;
            r_byte    <= '0;
            r_chk     <= '0;
            r_tx_data <= r_snap[0][7:0];
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ r_tx_data;
            if (w_last) begin
              r_state   <= S_CHECKSUM;
              r_tx_data <= r_chk ^ r_tx_data;
            end else begin
              r_word    <= w_next_word;
              r_byte    <= w_next_byte;
              r_tx_data <= w_next_data;
            end
          end
        end
        S_CHECKSUM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            if (r_clr) begin
              r_state     <= S_CLEAR;
              r_resethist <= 1'b1;
              r_cnt       <= CW'(CLR_WAIT);
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          // The pulse cycle plus CLR_WAIT further cycles cover the accumulator sweep.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign resethist = r_resethist;
  assign done      = r_done;

endmodule

// File: doc/histo_readout.md
Name: histo_readout

Overview:
- Reads out the photon-count histograms (8 channel counters plus 64 inter-photon-interval bins) to the host-link byte stream.
- On a host request, snapshots all 72 bins in one cycle and streams them as a framed byte sequence over a valid/ready interface.
- Optionally pulses the accumulator's resethist input once the frame is done, then holds busy until the accumulator's clear sequence has finished.

Parameters:
- NHISTO, 8, number of channel histogram words.
- NIPI, 64, number of interval histogram words.
- CLR_WAIT, 70, cycles busy stays high after the resethist pulse; must exceed the accumulator's 65-cycle clear sweep.
- HDR, 8'hA5, frame header byte.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- histo  in  NHISTO*32  channel bins, flattened; word i at [32i+31:32i].
- ipihist  in  NIPI*32  interval bins, flattened; same packing.
- req  in  1  readout request, sampled each cycle.
- clear_after  in  1  sampled together with an accepted req; 1 requests a resethist pulse after the frame.
- tx_data  out  8  byte to the link.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  link accepts the byte.
- busy  out  1  high from req acceptance through the end of the frame, plus any clear wait.
- resethist  out  1  one-cycle clear pulse to the accumulator.
- done  out  1  one-cycle pulse when the readout completes.

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; tx_valid=0, tx_data=0, busy=0, resethist=0, done=0; counters and checksum cleared. This applies in any state, including mid-frame. A partial frame is abandoned and no resethist is issued.
- A byte transfers on an edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops without a transfer.
- IDLE: req=1 at edge N is accepted.
  - All 72 words are copied to snapshot registers at edge N.
  - clear_after is latched at edge N.
  - busy=1 and tx_valid=1 with tx_data=HDR from cycle N+1.
  - State goes to HEADER.
- req while busy=1 is ignored, with no queuing.
- HEADER: on transfer, go to DATA with word index 0 and byte index 0. The checksum is cleared to 0.
- DATA: sends snapshot words in order histo[0..NHISTO-1], then ipihist[0..NIPI-1].
  - Each word is 4 bytes, least-significant byte first.
  - Each transferred byte is XORed into the 8-bit checksum.
  - After byte 3 of the last word transfers, go to CHECKSUM.
  - Data bytes total (NHISTO+NIPI)*4 = 288; the frame is 290 bytes.
- CHECKSUM: tx_data equals the XOR of all data bytes (header excluded). On transfer, tx_valid drops the next cycle.
  - If clear_after was latched: go to CLEAR.
  - Otherwise: go to IDLE, with done=1 for one cycle and busy=0 in that same cycle.
- CLEAR: resethist=1 for exactly one cycle, the cycle after the checksum transfer. Then busy stays high for CLR_WAIT further cycles. Then done pulses, busy=0, and the state returns to IDLE.
- Back-to-back: a req in the cycle done=1 is accepted, since busy=0 in that cycle.
- Snapshot isolation: changes on histo/ipihist after the accept edge never appear in the current frame.
- Link stalls of any length are tolerated. There is no timeout.
- Widths: word index is 7 bits; byte index is 2 bits; the CLEAR wait counter is sized by $clog2(CLR_WAIT+1).

Test Plan:
- Basic frame, tx_ready tied 1. Inputs: histo[i]=i+1, ipihist[j]=0x100+j, req pulse with clear_after=0.
  - Required: 290 consecutive bytes. Byte0=0xA5; bytes1-4 = 01 00 00 00; byte 33 = 0x00 (ipihist[0] LSB); byte 34 = 0x01.
  - Last byte equals the XOR of bytes 1-288. done pulses once; resethist never asserts.
- Random tx_ready at 30% duty, same inputs.
  - Required: identical byte sequence to the basic frame.
  - tx_data stable and tx_valid held through every stall cycle.
- Snapshot isolation: ramp histo[0] every cycle after accept.
  - Required: frame bytes 1-4 equal the value present at the accept edge.
- clear_after=1.
  - Required: resethist=1 for exactly one cycle, one cycle after the checksum transfer. busy stays high for 70 more cycles, then done pulses.
- req pulsed during a frame.
  - Required: ignored; exactly one frame.
  - req in the done cycle: a second frame starts the next cycle with header 0xA5.
- resetn=0 at byte 100 of a frame with clear_after=1.
  - Required: next cycle tx_valid=0, busy=0, and resethist never pulses.
  - A following req produces a complete, correct 290-byte frame.
